// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_if
// Purpose  : Producer-side valid/ready streams and FIFO write port of the
//            round-robin FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_input_data;
    logic                          fifo_write;
    logic                          fifo_full;
    logic                          busy;
    logic [ID_W-1:0]               owner;

    // Producers plus the FIFO status side drive the bus.
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_input_data, fifo_write, busy, owner
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_input_data, fifo_write, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-bounded arbiter sharing one FIFO write port
//            between NUM_REQ valid/ready producers.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST      = 4,
    parameter int ID_W       = 2
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.slave   bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0]      c_last_beat = 8'(BURST - 1);
    localparam logic [ID_W-1:0] c_last_id   = ID_W'(NUM_REQ - 1);

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_owner;
    logic [7:0]            r_burst_cnt;

    state_t                w_state_nxt;
    logic [ID_W-1:0]       w_rr_nxt;
    logic [ID_W-1:0]       w_owner_nxt;
    logic [7:0]            w_cnt_nxt;

    logic [DATA_WIDTH-1:0] w_slices [NUM_REQ];
    logic                  w_owner_valid;
    logic                  w_xfer;
    logic                  w_any;
    logic [ID_W-1:0]       w_pick;
    int                    w_idx;
    logic [ID_W-1:0]       w_idx_id;
    logic [NUM_REQ-1:0]    w_ready;
    logic                  w_write;
    logic [ID_W-1:0]       w_owner_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slices[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_owner_valid = bus.req_valid[r_owner];
    assign w_xfer        = (r_state == BUSY) && w_owner_valid && !bus.fifo_full;
    // Explicit wrap keeps non-power-of-two NUM_REQ inside the legal range.
    assign w_owner_inc   = (r_owner == c_last_id) ? '0 : r_owner + ID_W'(1);

    // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_any    = 1'b0;
        w_pick   = r_rr_ptr;
        w_idx    = 0;
        w_idx_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_idx_id = ID_W'(w_idx);
            if (!w_any && bus.req_valid[w_idx_id]) begin
                w_any  = 1'b1;
                w_pick = w_idx_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_owner     <= w_owner_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_burst_cnt;
        w_ready     = '0;
        w_write     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_write = w_owner_valid;
                if (!bus.fifo_full) begin
                    w_ready = NUM_REQ'(1) << r_owner;
                end
                // Releasing owner moves to the back of the round-robin order.
                if (!w_owner_valid || (w_xfer && (r_burst_cnt == c_last_beat))) begin
                    w_state_nxt = IDLE;
                    w_rr_nxt    = w_owner_inc;
                    w_cnt_nxt   = '0;
                end else if (w_xfer) begin
                    w_cnt_nxt   = r_burst_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready       = w_ready;
    assign bus.fifo_write      = w_write;
    assign bus.fifo_input_data = w_slices[r_owner];
    assign bus.busy            = (r_state == BUSY);
    assign bus.owner           = r_owner;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of one `fifo` instance between `NUM_REQ` independent producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst, then forwards that producer's data onto `fifo.input_data`/`fifo.write` and back-pressures it from `fifo.full`. It sits directly in front of the FIFO and replaces per-producer write drivers.

## Interface
- `NUM_REQ`, default 4: number of producers, 2..16.
- `DATA_WIDTH`, default 32: word width; matches the FIFO data width.
- `BURST`, default 4: maximum accepted words per grant, 1..255.
- `ID_W`, default 2: width of owner index; must satisfy ceil(log2(NUM_REQ)) <= ID_W.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset; `reset`==0 resets immediately.
- `req_valid`, in, NUM_REQ: producer i has a word on its data slice.
- `req_data`, in, NUM_REQ*DATA_WIDTH: producer i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`, out, NUM_REQ: word of producer i is accepted this cycle.
- `fifo_input_data`, out, DATA_WIDTH: connects to FIFO `input_data`.
- `fifo_write`, out, 1: connects to FIFO `write`.
- `fifo_full`, in, 1: connects to FIFO `full`.
- `busy`, out, 1: a grant is held (state BUSY).
- `owner`, out, ID_W: index of the current or last grantee.

## Operation
- **Transfer rule:** a transfer occurs when the arbiter is in BUSY and `req_valid[owner]`=1 and `fifo_full`=0.
- **State machine:** two states, IDLE and BUSY.
- **Registers:** `state`, `rr_ptr` (ID_W bits), `owner` (ID_W bits), `burst_cnt` (8 bits).
- **IDLE:**
  - All `req_ready`=0, `fifo_write`=0.
  - If any `req_valid` is set, select the first valid index scanning upward from `rr_ptr` and wrapping modulo NUM_REQ.
  - Register that index in `owner`, clear `burst_cnt`, and go to BUSY.
- **BUSY outputs:**
  - `fifo_write` = `req_valid[owner]`.
  - `fifo_input_data` = data slice of `owner`.
  - `req_ready[owner]` = !`fifo_full`; every other `req_ready`=0.
- **BUSY counting:** on each transfer, `burst_cnt` increments.
- **Release:** leave BUSY for IDLE when either condition holds:
  - a transfer occurs with `burst_cnt`==BURST-1 (last beat); or
  - `req_valid[owner]`=0 (the producer dropped valid).
- **On release:** `rr_ptr` <= (`owner`+1) mod NUM_REQ, and `burst_cnt` <= 0.
- **FIFO full:** while `fifo_full`=1 in BUSY, the grant is held, `burst_cnt` holds, and `fifo_write` follows `req_valid[owner]`. The FIFO ignores writes while full; there is no timeout.
- **Data output in IDLE:** `fifo_input_data` is don't-care when `fifo_write`=0; it is driven with the `owner` slice.
- **Producer rule:** a producer must hold `req_valid` and its data stable until `req_ready` is seen. Data ordering within one producer is preserved.
- **Width and wrap:** `rr_ptr` and `owner` wrap modulo NUM_REQ. Non-power-of-two NUM_REQ wraps explicitly from NUM_REQ-1 to 0.

## Timing
- **Reset values** (asynchronous, while `reset`=0):
  - `state`=IDLE, `rr_ptr`=0, `owner`=0, `burst_cnt`=0.
  - `busy`=0, `fifo_write`=0, `req_ready`=0.
- **Reset mid-burst:** outputs drop in the same cycle; words already written stay in the FIFO; the partial burst is abandoned.
- **Arbitration latency:** 1 cycle. A valid seen in IDLE at edge k gives a grant, and the first possible transfer, in cycle k+1.
- **Throughput:** with no back-pressure, each grant moves BURST words in BURST cycles, followed by one IDLE cycle. One producer streaming continuously therefore gets BURST/(BURST+1) of port bandwidth.
- **Combinational paths:** all outputs are combinational from registered state plus `req_valid`/`req_data`/`fifo_full`. There is no combinational path from `req_ready` back to `req_valid`.
- **Simultaneous events:** last-beat release and new requests in the same cycle resolve in the next IDLE cycle using the updated `rr_ptr`. The releasing owner is scanned last.

## Test plan
Default parameters throughout (NUM_REQ=4, DATA_WIDTH=32, BURST=4), with a DEPTH=16 FIFO attached and a reader that drains only when full.

1. **Reset:** hold `reset`=0 for 5 cycles, then release with all valids low -> `busy`=0, `fifo_write`=0, `req_ready`=4'b0000, `owner`=0.
2. **Single producer, bursting:** only producer 1 is valid, sending 10 words 0x100..0x109 -> bursts of 4, 4 and 2 words with one IDLE cycle between bursts. The FIFO holds 0x100..0x109 in order, and `owner`=1 throughout.
3. **Fairness:** all 4 producers valid continuously, producer i sending 0xi00+n -> grant order 0,1,2,3,0 with exactly 4 words per grant. The FIFO sequence starts 0x000..0x003, then 0x100..0x103.
4. **Back-pressure:** producer 2 is granted; force `fifo_full`=1 for 3 cycles after its 2nd word -> `req_ready[2]`=0 and `burst_cnt` holds at 2 during the stall. Exactly 4 words are accepted in total, with no duplicates or losses.
5. **Early drop:** producer 0 drops valid after 1 word while producers 0 and 1 are requesting -> release occurs after 1 word, and the next grant goes to producer 1.
6. **Wrap-around and async reset:** after producer 3 completes its last beat with producers 0 and 3 valid -> next grant is producer 0. Then assert `reset`=0 mid-burst -> `fifo_write` and `req_ready` drop within the same cycle.
